mvu_wrw_loader: RTL

//  Streaming weight-memory loader for the MVU array. Accepts a command (MVU mask, base address, length)
//  and a narrow data stream, assembles S_W-bit beats into BWBANKW-bit bank words, and writes them to the
//  mvu_wrw_* ports of every selected MVU (broadcast when mask has >1 bit). Sits between host/DMA and

---
 rtl/mvu_wrw_loader_pkg.sv | 22 ++
 rtl/mvu_wrw_loader_if.sv | 37 +++
 rtl/mvu_wrw_loader_gearbox.sv | 57 +++++
 rtl/mvu_wrw_loader.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mvu_wrw_loader_pkg.sv
// Shared types and default sizing for the MVU weight-write loader.
package mvu_wrw_loader_pkg;

  // Default array configuration; the loader and its interface take these as parameter defaults.
  localparam int unsigned MvuNmvu    = 8;
  localparam int unsigned MvuBwBankA = 9;
  localparam int unsigned MvuBwBankW = 4096;
  localparam int unsigned MvuSW      = 64;

  // Command as latched on acceptance, at the default sizing.
  typedef struct packed {
    logic [MvuNmvu-1:0]  mask;
    logic [MvuBwBankA-1:0] baddr;
    logic [MvuBwBankA:0]   len;
  } wrw_cmd_t;

  typedef enum logic [0:0] {
    StIdle,
    StLoad
  } wrw_ldr_state_e;

endpackage

// File: rtl/mvu_wrw_loader_if.sv
// Host/stream side and MVU write side of the weight-write loader.
interface mvu_wrw_loader_if
  import mvu_wrw_loader_pkg::*;
#(
  parameter int unsigned NMVU    = MvuNmvu,
  parameter int unsigned BWBANKA = MvuBwBankA,
  parameter int unsigned BWBANKW = MvuBwBankW,
  parameter int unsigned S_W     = MvuSW
) ();

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [NMVU-1:0]           cmd_mask;
  logic [BWBANKA-1:0]        cmd_baddr;
  logic [BWBANKA:0]          cmd_len;
  logic                      s_valid;
  logic                      s_ready;
  logic [S_W-1:0]            s_data;
  logic                      abort;
  logic [NMVU*BWBANKA-1:0]   mvu_wrw_addr;
  logic [NMVU*BWBANKW-1:0]   mvu_wrw_word;
  logic [NMVU-1:0]           mvu_wrw_en;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport master (
    output cmd_valid, cmd_mask, cmd_baddr, cmd_len, s_valid, s_data, abort,
    input  cmd_ready, s_ready, mvu_wrw_addr, mvu_wrw_word, mvu_wrw_en, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_mask, cmd_baddr, cmd_len, s_valid, s_data, abort,
    output cmd_ready, s_ready, mvu_wrw_addr, mvu_wrw_word, mvu_wrw_en, busy, done, err
  );

endinterface

// File: rtl/mvu_wrw_loader_gearbox.sv
// Assembles S_W-bit beats into a BWBANKW-bit word, little-endian by beat.
// Only the first BEATS-1 beats are stored; the final beat is merged combinationally so the
// full word is presented in the same cycle the last beat is accepted.
module mvu_wrw_loader_gearbox #(
  parameter int unsigned BWBANKW = 256,
  parameter int unsigned S_W     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               beat_valid_i,
  input  logic [S_W-1:0]     beat_data_i,
  output logic [BWBANKW-1:0] word_o,
  output logic               word_valid_o
);

  localparam int unsigned Beats = BWBANKW / S_W;
  localparam int unsigned BeatW = $clog2(Beats);

  logic [BeatW-1:0]         beat_q, beat_d;
  logic [BWBANKW-S_W-1:0]   asm_q, asm_d;
  logic                     last_beat;

  assign last_beat    = (beat_q == BeatW'(Beats - 1));
  assign word_o       = {beat_data_i, asm_q};
  assign word_valid_o = beat_valid_i & last_beat & ~clear_i;

  // Beat counter advance and storage of the non-final beats.
  always_comb begin
    beat_d = beat_q;
    asm_d  = asm_q;
    if (clear_i) begin
      beat_d = '0;
    end else if (beat_valid_i) begin
      if (last_beat) begin
        beat_d = '0;
      end else begin
        beat_d = beat_q + BeatW'(1);
        for (int k = 0; k < int'(Beats) - 1; k++) begin
          if (beat_q == BeatW'(k)) asm_d[k*S_W +: S_W] = beat_data_i;
        end
      end
    end
  end

  // Assembly state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      asm_q  <= '0;
    end else begin
      beat_q <= beat_d;
      asm_q  <= asm_d;
    end
  end

endmodule

// File: rtl/mvu_wrw_loader.sv
// Streaming weight-memory loader: takes a (mask, base, length) command and a narrow beat stream,
// and broadcasts each assembled bank word to every selected MVU write port.
module mvu_wrw_loader
  import mvu_wrw_loader_pkg::*;
#(
  parameter int unsigned NMVU    = MvuNmvu,
  parameter int unsigned BWBANKA = MvuBwBankA,
  parameter int unsigned BWBANKW = MvuBwBankW,
  parameter int unsigned S_W     = MvuSW
) (
  input logic               clk,
  input logic               rst_n,
  mvu_wrw_loader_if.slave   wrw_io
);

  typedef struct packed {
    logic [NMVU-1:0]    mask;
    logic [BWBANKA-1:0] baddr;
    logic [BWBANKA:0]   len;
  } cmd_t;

  wrw_ldr_state_e      state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [BWBANKA:0]    idx_q, idx_d;
  logic [NMVU-1:0]     en_q, en_d;
  logic [BWBANKA-1:0]  addr_q, addr_d;
  logic [BWBANKW-1:0]  word_q, word_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                in_load;
  logic                beat_acc;
  logic                gb_clear;
  logic                gb_valid;
  logic [BWBANKW-1:0]  gb_word;

  assign in_load  = (state_q == StLoad);
  // A beat that arrives together with abort is handshaked but dropped.
  assign beat_acc = in_load & wrw_io.s_valid & ~wrw_io.abort;

  // cmd_ready is gated by reset so every output reads 0 while rst_n is low.
  assign wrw_io.cmd_ready    = (state_q == StIdle) & rst_n;
  assign wrw_io.s_ready      = in_load;
  assign wrw_io.busy         = in_load;
  assign wrw_io.done         = done_q;
  assign wrw_io.err          = err_q;
  assign wrw_io.mvu_wrw_en   = en_q;
  assign wrw_io.mvu_wrw_addr = {NMVU{addr_q}};
  assign wrw_io.mvu_wrw_word = {NMVU{word_q}};

  mvu_wrw_loader_gearbox #(
    .BWBANKW (BWBANKW),
    .S_W     (S_W)
  ) u_gearbox (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (gb_clear),
    .beat_valid_i (beat_acc),
    .beat_data_i  (wrw_io.s_data),
    .word_o       (gb_word),
    .word_valid_o (gb_valid)
  );

  // Command decode, word sequencing and write-port next state.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    idx_d    = idx_q;
    en_d     = '0;
    addr_d   = addr_q;
    word_d   = word_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    gb_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wrw_io.cmd_valid) begin
          cmd_d = '{mask: wrw_io.cmd_mask, baddr: wrw_io.cmd_baddr, len: wrw_io.cmd_len};
          if ((wrw_io.cmd_len == '0) || (wrw_io.cmd_mask == '0)) begin
            err_d = 1'b1;
          end else begin
            state_d  = StLoad;
            idx_d    = '0;
            gb_clear = 1'b1;
          end
        end
      end
      StLoad: begin
        if (wrw_io.abort) begin
          state_d  = StIdle;
          gb_clear = 1'b1;
        end else if (gb_valid) begin
          en_d   = cmd_q.mask;
          // Address wraps modulo the bank depth.
          addr_d = cmd_q.baddr + idx_q[BWBANKA-1:0];
          word_d = gb_word;
          idx_d  = idx_q + (BWBANKA + 1)'(1);
          if (idx_q == cmd_q.len - (BWBANKA + 1)'(1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, command and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      idx_q   <= '0;
      en_q    <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule
